// File: rtl/dataflow_fifo_pkg.sv
// Shared definitions for the broadcast (fork) FIFO: error-flag bit positions
// and width helpers for pointers and per-reader occupancy counters.
package dataflow_fifo_pkg;

    localparam int ERR_OVF_BIT = 0;
    localparam int ERR_UDF_BIT = 1;

    // Bit width of an index range, never below one bit.
    function automatic int clog2_min1(input int value);
        return (value < 2) ? 1 : $clog2(value);
    endfunction

    // Width of a per-reader count, which must hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return clog2_min1(depth + 1);
    endfunction

endpackage

// File: rtl/fork_fifo_rd_port.sv
// One consumer port of the fork FIFO: owns the read pointer and occupancy
// count for a single reader and qualifies that reader's pop requests.
module fork_fifo_rd_port
    import dataflow_fifo_pkg::*;
#(
    parameter int DEPTH      = 5,
    parameter int ADDR_WIDTH = clog2_min1(DEPTH)
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  push_i,
    input  logic                  read_i,
    input  logic                  read_ce_i,
    output logic [ADDR_WIDTH-1:0] rd_ptr_o,
    output logic                  empty_n_o,
    output logic                  full_o,
    output logic                  underflow_o
);

    localparam int CNT_W = cnt_width(DEPTH);
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t                  CNT_FULL = cnt_t'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);

    cnt_t                  cnt_q;
    cnt_t                  cnt_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_d;
    logic                  pop;

    // Status comes only from registered state, never from this cycle's request.
    assign empty_n_o   = (cnt_q != '0);
    assign full_o      = (cnt_q == CNT_FULL);
    assign pop         = read_i & read_ce_i & empty_n_o;
    assign underflow_o = read_i & read_ce_i & ~empty_n_o;
    assign rd_ptr_o    = rd_ptr_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);
        end
        cnt_d = cnt_q;
        case ({push_i, pop})
            2'b10:   cnt_d = cnt_q + cnt_t'(1);
            2'b01:   cnt_d = cnt_q - cnt_t'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/dataflow_fork_fifo.sv
// Single-writer, NUM_RD-reader broadcast FIFO; each entry frees once every
// reader has popped it. Define DATAFLOW_FORK_FIFO_ERR_EN for sticky error flags.
module dataflow_fork_fifo
    import dataflow_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 5,
    parameter int NUM_RD     = 2,
    parameter int ADDR_WIDTH = clog2_min1(DEPTH)
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         if_write_ce,
    input  logic                         if_write,
    input  logic [DATA_WIDTH-1:0]        if_din,
    output logic                         if_full_n,
    input  logic [NUM_RD-1:0]            if_read_ce,
    input  logic [NUM_RD-1:0]            if_read,
    output logic [NUM_RD*DATA_WIDTH-1:0] if_dout,
    output logic [NUM_RD-1:0]            if_empty_n,
    output logic [1:0]                   err_flags
);

    // Handshake: a push completes when if_write & if_write_ce & if_full_n, a pop
    // on reader i when if_read[i] & if_read_ce[i] & if_empty_n[i]; the flags are
    // decided from registered counts, so a full FIFO with a pop pending stays full.

    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr [NUM_RD];
    logic [NUM_RD-1:0]     rd_full;
    logic [NUM_RD-1:0]     udf_vec;
    logic                  push;

    assign if_full_n = ~|rd_full;
    assign push      = if_write & if_write_ce & if_full_n;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by the counts.
    always_ff @(posedge ap_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= if_din;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        fork_fifo_rd_port #(
            .DEPTH      (DEPTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_rd_port (
            .ap_clk      (ap_clk),
            .ap_rst_n    (ap_rst_n),
            .push_i      (push),
            .read_i      (if_read[g]),
            .read_ce_i   (if_read_ce[g]),
            .rd_ptr_o    (rd_ptr[g]),
            .empty_n_o   (if_empty_n[g]),
            .full_o      (rd_full[g]),
            .underflow_o (udf_vec[g])
        );

        assign if_dout[g*DATA_WIDTH +: DATA_WIDTH] = mem[rd_ptr[g]];
    end

`ifdef DATAFLOW_FORK_FIFO_ERR_EN
    logic [1:0] err_q;
    logic [1:0] err_d;

    always_comb begin
        err_d = err_q;
        if (if_write & if_write_ce & ~if_full_n) begin
            err_d[ERR_OVF_BIT] = 1'b1;
        end
        if (|udf_vec) begin
            err_d[ERR_UDF_BIT] = 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_flags = err_q;
`else
    logic unused_udf;
    assign unused_udf = ^udf_vec;
    assign err_flags  = 2'b00;
`endif

endmodule
